// File: rtl/compound_out_arbiter_if.sv
// CompoundType payload definition and the shared producer/consumer bus.

package testbasic11_types;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_e;

    typedef struct packed {
        mode_e              mode;
        logic signed [31:0] x;
        logic               y;
    } compound_t;

endpackage

// Producer request lines plus the blocking CompoundType output port.
interface compound_out_if #(
    parameter int unsigned NUM_REQ = 4
);
    import testbasic11_types::*;

    logic      [NUM_REQ-1:0] req_valid;
    compound_t [NUM_REQ-1:0] req_data;
    logic      [NUM_REQ-1:0] req_ack;
    compound_t               b_out;
    logic                    b_out_notify;
    logic                    b_out_sync;

    // Arbiter side: consumes requests, drives the offer and acks.
    modport master (
        input  req_valid,
        input  req_data,
        input  b_out_sync,
        output req_ack,
        output b_out,
        output b_out_notify
    );

    // Environment side: producers and the downstream consumer.
    modport slave (
        output req_valid,
        output req_data,
        output b_out_sync,
        input  req_ack,
        input  b_out,
        input  b_out_notify
    );

endinterface

// File: rtl/compound_out_arbiter.sv
// Round-robin arbiter sharing one blocking CompoundType output among NUM_REQ
// producers, with optional precedence for write-mode requests.

module compound_out_arbiter
    import testbasic11_types::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned WRITE_PRIO = 0,
    parameter  int unsigned STALL_W    = 16,
    localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    compound_out_if.master        bus,
    output logic [IDX_W-1:0]      grant_idx,
    output logic [STALL_W-1:0]    stall_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e               state_q;
    state_e               state_d;
    compound_t            b_out_d;
    logic                 notify_d;
    logic [IDX_W-1:0]     grant_d;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic [STALL_W-1:0]   stall_d;

    logic [NUM_REQ-1:0]   scan_mask;
    logic [NUM_REQ-1:0]   wr_mask;
    logic [NUM_REQ-1:0]   pick_mask;
    logic [IDX_W-1:0]     scan_ptr;
    logic [IDX_W-1:0]     next_ptr;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;

    // Index base+off modulo NUM_REQ; both operands are below NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                   input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin successor of the current owner.
    always_comb begin
        next_ptr = grant_idx + IDX_W'(1);
        if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end
    end

    // Candidate set: in OFFER the current owner is excluded and the scan
    // starts just after it, so a transfer edge can hand over back-to-back.
    always_comb begin
        scan_mask = bus.req_valid;
        scan_ptr  = rr_ptr_q;
        if (state_q == OFFER) begin
            scan_mask[grant_idx] = 1'b0;
            scan_ptr             = next_ptr;
        end
    end

    // Write-class filter; read requests compete only when no write is valid.
    always_comb begin
        wr_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wr_mask[i] = scan_mask[i] && (bus.req_data[i].mode == MODE_WRITE);
        end
        pick_mask = scan_mask;
        if ((WRITE_PRIO != 0) && (|wr_mask)) begin
            pick_mask = wr_mask;
        end
    end

    // First set bit of pick_mask at or after scan_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = wrap_idx(scan_ptr, k);
            if (!win_found && pick_mask[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic for the offer FSM.
    always_comb begin
        state_d  = state_q;
        b_out_d  = bus.b_out;
        notify_d = bus.b_out_notify;
        grant_d  = grant_idx;
        rr_ptr_d = rr_ptr_q;
        stall_d  = stall_cnt;
        case (state_q)
            IDLE: begin
                notify_d = 1'b0;
                if (win_found) begin
                    state_d  = OFFER;
                    b_out_d  = bus.req_data[win_idx];
                    grant_d  = win_idx;
                    notify_d = 1'b1;
                end
            end
            OFFER: begin
                if (bus.b_out_sync) begin
                    rr_ptr_d = next_ptr;
                    if (win_found) begin
                        b_out_d  = bus.req_data[win_idx];
                        grant_d  = win_idx;
                        notify_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        notify_d = 1'b0;
                    end
                end else if (stall_cnt != '1) begin
                    stall_d = stall_cnt + STALL_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                notify_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any pending offer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            bus.b_out        <= '0;
            bus.b_out_notify <= 1'b0;
            grant_idx        <= '0;
            rr_ptr_q         <= '0;
            stall_cnt        <= '0;
        end else begin
            state_q          <= state_d;
            bus.b_out        <= b_out_d;
            bus.b_out_notify <= notify_d;
            grant_idx        <= grant_d;
            rr_ptr_q         <= rr_ptr_d;
            stall_cnt        <= stall_d;
        end
    end

    // Ack the owner in the cycle the consumer takes the offer.
    always_comb begin
        bus.req_ack = '0;
        if (bus.b_out_notify && bus.b_out_sync) begin
            bus.req_ack[grant_idx] = 1'b1;
        end
    end

endmodule
